// File: rtl/data_mem_stage_if.sv
// Bus between the EX/MEM pipeline register and the memory-access stage.
// The master drives a load/store request. The slave returns load data,
// the pipeline stall, the illegal-request flag and the error counter.
interface data_mem_stage_if;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        stall;
  logic        misaligned;
  logic [7:0]  err_count;

  modport master (
    output mem_read, mem_write, mem_size, mem_unsigned, addr, write_data,
    input  read_data, stall, misaligned, err_count
  );

  modport slave (
    input  mem_read, mem_write, mem_size, mem_unsigned, addr, write_data,
    output read_data, stall, misaligned, err_count
  );
endinterface

// File: rtl/data_mem_stage.sv
// MIPS memory-access stage.
// Fixed-latency on-chip data RAM with little-endian byte/halfword lanes and
// sign/zero extension on loads. The stage holds the upstream pipeline with
// stall while an access is in flight. Each accepted access walks through
// IDLE -> BUSY (LATENCY cycles) -> DONE.
module data_mem_stage #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  data_mem_stage_if.slave bus
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_r;
  logic [3:0]    cnt_r;
  logic [AW+1:0] addr_r;
  logic [31:0]   wdata_r;
  logic [1:0]    size_r;
  logic          uns_r;
  logic          is_write_r;
  logic [31:0]   read_data_r;
  logic [7:0]    err_count_r;
  logic          ready_r;

  logic [31:0]   ram [DEPTH_WORDS];

  logic          req_s;
  logic          legal_s;
  logic          accept_s;
  logic          reject_s;
  logic          commit_s;
  logic [AW-1:0] widx_s;
  logic [31:0]   rword_s;
  logic [31:0]   rext_s;
  logic [31:0]   wmerge_s;
  logic [7:0]    rbyte_s;
  logic [15:0]   rhalf_s;
  logic          unused_addr_s;

  // Address bits above the RAM size are ignored, so addresses wrap.
  assign unused_addr_s = ^bus.addr[31:AW+2];

  // Request decode: classify the incoming request as accepted or rejected.
  // ready_r keeps the unit quiet while reset is held.
  always_comb begin
    req_s = bus.mem_read | bus.mem_write;
    case (bus.mem_size)
      2'b00:   legal_s = 1'b1;
      2'b01:   legal_s = ~bus.addr[0];
      2'b10:   legal_s = (bus.addr[1:0] == 2'b00);
      default: legal_s = 1'b0;
    endcase
    if ((state_r == IDLE) && ready_r) begin
      accept_s = req_s & legal_s;
      reject_s = req_s & ~legal_s;
    end else begin
      accept_s = 1'b0;
      reject_s = 1'b0;
    end
  end

  assign commit_s       = (state_r == BUSY) && (cnt_r == 4'd0);
  assign bus.stall      = accept_s | (state_r == BUSY);
  assign bus.misaligned = reject_s;
  assign bus.read_data  = read_data_r;
  assign bus.err_count  = err_count_r;

  // Lane logic: extract and extend load data, and merge store data into the addressed word.
  always_comb begin
    widx_s   = addr_r[AW+1:2];
    rword_s  = ram[widx_s];
    rbyte_s  = rword_s[{addr_r[1:0], 3'b000} +: 8];
    rhalf_s  = rword_s[{addr_r[1], 4'b0000} +: 16];
    rext_s   = rword_s;
    wmerge_s = rword_s;
    case (size_r)
      2'b00: begin
        if (uns_r) begin
          rext_s = {24'd0, rbyte_s};
        end else begin
          rext_s = {{24{rbyte_s[7]}}, rbyte_s};
        end
        wmerge_s[{addr_r[1:0], 3'b000} +: 8] = wdata_r[7:0];
      end
      2'b01: begin
        if (uns_r) begin
          rext_s = {16'd0, rhalf_s};
        end else begin
          rext_s = {{16{rhalf_s[15]}}, rhalf_s};
        end
        wmerge_s[{addr_r[1], 4'b0000} +: 16] = wdata_r[15:0];
      end
      2'b10: begin
        rext_s   = rword_s;
        wmerge_s = wdata_r;
      end
      default: begin
        rext_s   = rword_s;
        wmerge_s = wdata_r;
      end
    endcase
  end

  // Reset-release qualifier: requests are taken from the first full cycle after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r <= 1'b0;
    end else begin
      ready_r <= 1'b1;
    end
  end

  // Access FSM: latch the request, count down the latency, commit loads, and count rejects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      addr_r      <= '0;
      wdata_r     <= 32'd0;
      size_r      <= 2'b00;
      uns_r       <= 1'b0;
      is_write_r  <= 1'b0;
      read_data_r <= 32'd0;
      err_count_r <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            addr_r     <= bus.addr[AW+1:0];
            wdata_r    <= bus.write_data;
            size_r     <= bus.mem_size;
            uns_r      <= bus.mem_unsigned;
            is_write_r <= bus.mem_write;
            cnt_r      <= CNT_INIT;
            state_r    <= BUSY;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            state_r <= DONE;
            if (!is_write_r) begin
              read_data_r <= rext_s;
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
      if (reject_s && (err_count_r != 8'hFF)) begin
        err_count_r <= err_count_r + 8'd1;
      end
    end
  end

  // RAM write port: a store lands only at its commit edge. The RAM is not reset.
  always_ff @(posedge clk) begin
    if (commit_s && is_write_r) begin
      ram[widx_s] <= wmerge_s;
    end
  end

endmodule

// File: tb/tb_data_mem_stage.sv
// Testbench for data_mem_stage.
// It applies a table of load/store vectors. Each expected read_data value is
// queued when the request is driven and popped in the completion cycle.
// Hand-written sequences cover reset, reset during an access, and
// err_count saturation.
module tb_data_mem_stage;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  data_mem_stage_if bus();

  data_mem_stage #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] a;
    logic [31:0] wd;
    logic        mis;
    logic [31:0] exp;
  } vec_t;

  int          n_vec = 0;
  int          n_err = 0;
  int          exp_err = 0;
  logic [31:0] sb_q[$];
  vec_t        vecs[29];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  task automatic idle_inputs();
    bus.mem_read     = 1'b0;
    bus.mem_write    = 1'b0;
    bus.mem_size     = 2'b10;
    bus.mem_unsigned = 1'b0;
    bus.addr         = 32'd0;
    bus.write_data   = 32'd0;
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] sz,
                              input logic uns, input logic [31:0] a, input logic [31:0] wd,
                              input logic mis, input logic [31:0] exp);
    vec_t v;
    v.rd = rd; v.wr = wr; v.sz = sz; v.uns = uns;
    v.a = a; v.wd = wd; v.mis = mis; v.exp = exp;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int          n;
    logic [31:0] want;
    @(negedge clk);
    bus.mem_read     = v.rd;
    bus.mem_write    = v.wr;
    bus.mem_size     = v.sz;
    bus.mem_unsigned = v.uns;
    bus.addr         = v.a;
    bus.write_data   = v.wd;
    sb_q.push_back(v.exp);
    #1;
    if (v.mis) begin
      check32($sformatf("v%0d misaligned", idx), {31'd0, bus.misaligned}, 32'd1);
      check32($sformatf("v%0d stall_on_illegal", idx), {31'd0, bus.stall}, 32'd0);
      @(posedge clk);
      #1;
      if (exp_err < 255) exp_err++;
    end else begin
      n = 0;
      while (bus.stall === 1'b1 && n < 50) begin
        @(posedge clk);
        #1;
        n++;
      end
      check32($sformatf("v%0d stall_cycles", idx), 32'(n), 32'(LAT + 1));
    end
    if (sb_q.size() == 0) begin
      want = 32'hxxxxxxxx;
    end else begin
      want = sb_q.pop_front();
    end
    check32($sformatf("v%0d read_data", idx), bus.read_data, want);
    check32($sformatf("v%0d err_count", idx), {24'd0, bus.err_count}, 32'(exp_err));
    idle_inputs();
    @(posedge clk);
  endtask

  initial begin
    // rd wr size uns addr wdata mis expected read_data
    vecs[0]  = mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h10,  32'hDEADBEEF, 1'b0, 32'h00000000);
    vecs[1]  = mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF);
    vecs[2]  = mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h20,  32'h11223344, 1'b0, 32'hDEADBEEF);
    vecs[3]  = mk(1'b1, 1'b0, 2'b00, 1'b0, 32'h23,  32'h0,        1'b0, 32'h00000011);
    vecs[4]  = mk(1'b1, 1'b0, 2'b00, 1'b0, 32'h20,  32'h0,        1'b0, 32'h00000044);
    vecs[5]  = mk(1'b0, 1'b1, 2'b00, 1'b0, 32'h21,  32'h000000AA, 1'b0, 32'h00000044);
    vecs[6]  = mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h20,  32'h0,        1'b0, 32'h1122AA44);
    vecs[7]  = mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h30,  32'h8000FF80, 1'b0, 32'h1122AA44);
    vecs[8]  = mk(1'b1, 1'b0, 2'b00, 1'b0, 32'h30,  32'h0,        1'b0, 32'hFFFFFF80);
    vecs[9]  = mk(1'b1, 1'b0, 2'b00, 1'b1, 32'h30,  32'h0,        1'b0, 32'h00000080);
    vecs[10] = mk(1'b1, 1'b0, 2'b01, 1'b0, 32'h32,  32'h0,        1'b0, 32'hFFFF8000);
    vecs[11] = mk(1'b1, 1'b0, 2'b01, 1'b1, 32'h32,  32'h0,        1'b0, 32'h00008000);
    vecs[12] = mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h22,  32'h0,        1'b1, 32'h00008000);
    vecs[13] = mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h20,  32'h0,        1'b0, 32'h1122AA44);
    vecs[14] = mk(1'b0, 1'b1, 2'b01, 1'b0, 32'h31,  32'h00001234, 1'b1, 32'h1122AA44);
    vecs[15] = mk(1'b1, 1'b0, 2'b11, 1'b0, 32'h20,  32'h0,        1'b1, 32'h1122AA44);
    vecs[16] = mk(1'b0, 1'b1, 2'b01, 1'b0, 32'h22,  32'h9999BEEF, 1'b0, 32'h1122AA44);
    vecs[17] = mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h20,  32'h0,        1'b0, 32'hBEEFAA44);
    vecs[18] = mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h400, 32'hCAFEF00D, 1'b0, 32'hBEEFAA44);
    vecs[19] = mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h000, 32'h0,        1'b0, 32'hCAFEF00D);
    vecs[20] = mk(1'b1, 1'b1, 2'b10, 1'b0, 32'h44,  32'h0BADC0DE, 1'b0, 32'hCAFEF00D);
    vecs[21] = mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h44,  32'h0,        1'b0, 32'h0BADC0DE);
    vecs[22] = mk(1'b1, 1'b0, 2'b01, 1'b0, 32'h12,  32'h0,        1'b0, 32'hFFFFDEAD);
    vecs[23] = mk(1'b1, 1'b0, 2'b00, 1'b1, 32'h13,  32'h0,        1'b0, 32'h000000DE);
    vecs[24] = mk(1'b1, 1'b0, 2'b00, 1'b0, 32'h11,  32'h0,        1'b0, 32'hFFFFFFBE);
    vecs[25] = mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h40,  32'h77777777, 1'b0, 32'hFFFFFFBE);
    vecs[26] = mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF);
    vecs[27] = mk(1'b0, 1'b1, 2'b00, 1'b0, 32'h13,  32'h12345601, 1'b0, 32'hDEADBEEF);
    vecs[28] = mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        1'b0, 32'h01ADBEEF);

    // Reset state: outputs stay quiet even with an illegal request present.
    rst_n            = 1'b0;
    bus.mem_read     = 1'b1;
    bus.mem_write    = 1'b0;
    bus.mem_size     = 2'b11;
    bus.mem_unsigned = 1'b0;
    bus.addr         = 32'h22;
    bus.write_data   = 32'd0;
    #1;
    check32("reset stall", {31'd0, bus.stall}, 32'd0);
    check32("reset misaligned", {31'd0, bus.misaligned}, 32'd0);
    check32("reset read_data", bus.read_data, 32'd0);
    check32("reset err_count", {24'd0, bus.err_count}, 32'd0);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);

    for (int i = 0; i < 29; i++) begin
      run_vec(vecs[i], i);
    end

    // Reset in the first BUSY cycle abandons the store to 0x40.
    @(negedge clk);
    bus.mem_write  = 1'b1;
    bus.mem_size   = 2'b10;
    bus.addr       = 32'h40;
    bus.write_data = 32'h00000055;
    @(posedge clk);
    #1;
    check32("midrst busy stall", {31'd0, bus.stall}, 32'd1);
    #2;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check32("midrst stall", {31'd0, bus.stall}, 32'd0);
    check32("midrst read_data", bus.read_data, 32'd0);
    check32("midrst err_count", {24'd0, bus.err_count}, 32'd0);
    exp_err = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check32("post-reset stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clk);
    run_vec(mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0, 32'h77777777), 100);

    // Back-to-back illegal cycles saturate err_count at 255.
    @(negedge clk);
    bus.mem_read = 1'b1;
    bus.mem_size = 2'b10;
    bus.addr     = 32'h22;
    repeat (300) @(posedge clk);
    #1;
    check32("sat err_count", {24'd0, bus.err_count}, 32'd255);
    check32("sat misaligned", {31'd0, bus.misaligned}, 32'd1);
    check32("sat read_data", bus.read_data, 32'h77777777);
    idle_inputs();
    @(posedge clk);
    #1;
    check32("sat stall idle", {31'd0, bus.stall}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
